// File: rtl/imm_extend_queue.sv
// Immediate-extension unit for MIPS decode: opcode-driven zero/sign/upper/branch extension
// feeding a DEPTH-entry valid/ready FIFO with a registered head output.
module imm_extend_queue #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_data,
  input  logic [5:0]       i_opcode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic [1:0]       o_mode,
  output logic [LVL_W-1:0] o_level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ModeSign   = 2'b00,
    ModeZero   = 2'b01,
    ModeUpper  = 2'b10,
    ModeBranch = 2'b11
  } mode_e;

  logic [OUT_W-1:0] mem_data_q [DEPTH];
  logic [1:0]       mem_mode_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, head_idx;
  logic [LVL_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [1:0]       head_mode_q, head_mode_d;

  logic [OUT_W-1:0] sext, ext_data;
  mode_e            ext_mode;
  logic             push, pop;

  // Extension is computed from the raw field; the branch form drops the top two sign bits.
  always_comb begin
    sext = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};
    case (i_opcode)
      6'h0C, 6'h0D, 6'h0E: begin
        ext_mode = ModeZero;
        ext_data = {{(OUT_W-IN_W){1'b0}}, i_data};
      end
      6'h0F: begin
        ext_mode = ModeUpper;
        ext_data = {i_data, {(OUT_W-IN_W){1'b0}}};
      end
      6'h04, 6'h05: begin
        ext_mode = ModeBranch;
        ext_data = sext << 2;
      end
      default: begin
        ext_mode = ModeSign;
        ext_data = sext;
      end
    endcase
  end

  assign o_ready = (level_q < LVL_W'(DEPTH));
  assign o_valid = (level_q != '0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Head register tracks what will sit at the read pointer after this edge, so the output
  // holds its last value once the queue drains.
  always_comb begin
    head_data_d = head_data_q;
    head_mode_d = head_mode_q;
    head_idx    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (level_d != '0) begin
      if (push && (head_idx == wr_ptr_q)) begin
        head_data_d = ext_data;
        head_mode_d = ext_mode;
      end else begin
        head_data_d = mem_data_q[head_idx];
        head_mode_d = mem_mode_q[head_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_data_q <= '0;
      head_mode_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data_q[i] <= '0;
        mem_mode_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= ext_data;
        mem_mode_q[wr_ptr_q] <= ext_mode;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q     <= level_d;
      head_data_q <= head_data_d;
      head_mode_q <= head_mode_d;
    end
  end

  assign o_data  = head_data_q;
  assign o_mode  = head_mode_q;
  assign o_level = level_q;

endmodule

// File: tb/tb_imm_extend_queue.sv
// Directed bench for imm_extend_queue: extension modes, full/empty handshakes, wrap, async reset.
module tb_imm_extend_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [15:0] i_data;
  logic [5:0]  i_opcode;
  logic [31:0] o_data;
  logic [1:0]  o_mode;
  logic [2:0]  o_level;

  int checks = 0;
  int errors = 0;

  imm_extend_queue #(
    .IN_W (16),
    .OUT_W(32),
    .DEPTH(4),
    .LVL_W(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_opcode(i_opcode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_mode  (o_mode),
    .o_level (o_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] d, input logic [1:0] m,
                      input logic [2:0] lvl);
    check({tag, "_data"}, o_data, d);
    check({tag, "_mode"}, {30'd0, o_mode}, {30'd0, m});
    check({tag, "_level"}, {29'd0, o_level}, {29'd0, lvl});
  endtask

  initial begin
    reset    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data   = '0;
    i_opcode = '0;
    #12;
    check("rst_level", {29'd0, o_level}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_data", o_data, 32'd0);
    reset = 1'b1;
    step();

    // Extension modes, consumer always ready: each push replaces the previous head.
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_opcode = 6'h0C; i_data = 16'h8000; step();
    head("andi", 32'h0000_8000, 2'b01, 3'd1);
    check("andi_valid", {31'd0, o_valid}, 32'd1);
    i_opcode = 6'h08; i_data = 16'h8000; step();
    head("addi_neg", 32'hFFFF_8000, 2'b00, 3'd1);
    i_opcode = 6'h08; i_data = 16'h7FFF; step();
    head("addi_pos", 32'h0000_7FFF, 2'b00, 3'd1);
    i_opcode = 6'h0F; i_data = 16'h1234; step();
    head("lui", 32'h1234_0000, 2'b10, 3'd1);
    i_opcode = 6'h04; i_data = 16'hFFFF; step();
    head("beq", 32'hFFFF_FFFC, 2'b11, 3'd1);
    i_opcode = 6'h05; i_data = 16'h4001; step();
    head("bne", 32'h0001_0004, 2'b11, 3'd1);
    i_opcode = 6'h0E; i_data = 16'hFFFF; step();
    head("xori", 32'h0000_FFFF, 2'b01, 3'd1);
    i_valid = 1'b0; step();
    head("empty_hold", 32'h0000_FFFF, 2'b01, 3'd0);
    check("empty_valid", {31'd0, o_valid}, 32'd0);

    // Fill with the consumer stalled; the fifth offer must not be written.
    i_ready  = 1'b0;
    i_valid  = 1'b1;
    i_opcode = 6'h08;
    for (int k = 1; k <= 4; k++) begin
      i_data = 16'(k);
      step();
    end
    head("full", 32'd1, 2'b00, 3'd4);
    check("full_ready", {31'd0, o_ready}, 32'd0);
    i_data = 16'd5; step();
    head("overflow", 32'd1, 2'b00, 3'd4);

    // Full with both sides active: only the pop happens.
    i_ready = 1'b1; step();
    head("full_pop", 32'd2, 2'b00, 3'd3);
    check("full_pop_ready", {31'd0, o_ready}, 32'd1);

    // Steady push+pop for 10 cycles: both pointers wrap, level holds at 3.
    for (int k = 5; k <= 14; k++) begin
      i_data = 16'(k);
      step();
      head("stream", 32'(k - 2), 2'b00, 3'd3);
    end

    i_valid = 1'b0;
    step(); head("drain1", 32'd13, 2'b00, 3'd2);
    step(); head("drain2", 32'd14, 2'b00, 3'd1);
    step(); head("drain3", 32'd14, 2'b00, 3'd0);

    // Async reset in the middle of a cycle with two entries queued.
    i_ready  = 1'b0;
    i_valid  = 1'b1;
    i_opcode = 6'h0D;
    i_data   = 16'h00A1; step();
    i_data   = 16'h00A2; step();
    check("pre_rst_level", {29'd0, o_level}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_level", {29'd0, o_level}, 32'd0);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_data", o_data, 32'd0);
    check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    i_opcode = 6'h0F;
    i_data   = 16'h00AB;
    #2 reset = 1'b1;
    step();
    head("post_rst", 32'h00AB_0000, 2'b10, 3'd1);
    check("post_rst_valid", {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
